// File: rtl/fringe_xchg_sched_if.sv
// Put handshake between the exchange scheduler (master) and the fringe transport (slave).
interface fringe_xchg_sched_if #(
    parameter int PART_W = 1,
    parameter int CLK_W  = 2,
    parameter int DATA_W = 9
);
    logic              put_req;
    logic [PART_W-1:0] put_part;
    logic [CLK_W-1:0]  put_clk;
    logic [DATA_W-1:0] put_data;
    logic              put_ack;
    logic              put_err;

    modport master (output put_req, put_part, put_clk, put_data, input put_ack, put_err);
    modport slave  (input put_req, put_part, put_clk, put_data, output put_ack, put_err);
endinterface

// File: rtl/fringe_xchg_sched.sv
// Target-side fringe exchange scheduler: captures rows on mission-clock rising edges,
// queues them in a pool FIFO and issues them over a put handshake with retry/timeout.
module fringe_xchg_sched #(
    parameter int NUM_CLOCKS = 4,
    parameter int NUM_ROWS   = 4,
    parameter int NUM_PARTS  = 1,
    parameter int DATA_W     = 9,
    parameter int POOL_DEPTH = 4,
    parameter int MAX_RETRY  = 2,
    parameter int TIMEOUT    = 64,
    localparam int CLK_W  = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1,
    localparam int ROW_W  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1,
    localparam int PART_W = (NUM_PARTS > 1) ? $clog2(NUM_PARTS) : 1,
    localparam int LVL_W  = $clog2(POOL_DEPTH) + 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CLOCKS-1:0]        mclk_i,
    input  logic [NUM_ROWS*DATA_W-1:0]   row_data_i,
    input  logic                         cfg_we_i,
    input  logic [ROW_W-1:0]             cfg_row_i,
    input  logic [CLK_W-1:0]             cfg_clk_i,
    input  logic [PART_W-1:0]            cfg_part_i,
    input  logic                         cfg_mask_i,
    fringe_xchg_sched_if.master          put,
    output logic [NUM_CLOCKS-1:0]        freeze_clk_o,
    output logic                         busy_o,
    output logic [LVL_W-1:0]             pool_level_o,
    output logic [15:0]                  done_cnt_o,
    output logic                         overrun_o,
    output logic                         fail_o,
    output logic                         timeout_o,
    input  logic                         stat_clr_i
);
    localparam int ENT_W = PART_W + CLK_W + DATA_W;
    localparam int PTR_W = $clog2(POOL_DEPTH);
    localparam int INC_W = $clog2(NUM_ROWS + 1);
    localparam int CNT_W = $clog2(NUM_ROWS + POOL_DEPTH + 2);
    localparam int WD_W  = $clog2(TIMEOUT + 1);
    localparam int AT_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RETRY} state_t;

    logic [NUM_CLOCKS-1:0] mclk_s_reg, mclk_d_reg, mclk_edge;
    logic [CLK_W-1:0]      tbl_clk [NUM_ROWS];
    logic [ENT_W-1:0]      shadow  [NUM_ROWS];
    logic [NUM_ROWS-1:0]   pend, cap, clr, ovr_hit, fresh;
    logic [ROW_W-1:0]      ld_idx;
    logic                  push, pop, fifo_full, fifo_empty;
    logic [ENT_W-1:0]      pool_mem [POOL_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
    logic [LVL_W-1:0]      level_reg;
    logic [INC_W-1:0]      inc_next [NUM_CLOCKS];
    logic [INC_W-1:0]      inc_reg  [NUM_CLOCKS];
    logic [CNT_W-1:0]      out_reg  [NUM_CLOCKS];

    state_t                state_reg, state_next;
    logic                  req_reg, req_next;
    logic [AT_W-1:0]       attempt_reg, attempt_next;
    logic [WD_W-1:0]       wdog_reg, wdog_next;
    logic [PART_W-1:0]     part_reg;
    logic [CLK_W-1:0]      pclk_reg;
    logic [DATA_W-1:0]     data_reg;
    logic                  dec_en, done_inc, fail_set, tmo_set;

    // Two-flop sampling of the asynchronous mission clocks; only rising edges matter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mclk_s_reg <= '0;
            mclk_d_reg <= '0;
        end else begin
            mclk_s_reg <= mclk_i;
            mclk_d_reg <= mclk_s_reg;
        end
    end
    assign mclk_edge = mclk_s_reg & ~mclk_d_reg;

    generate
        for (genvar gi = 0; gi < NUM_ROWS; gi++) begin : g_row
            logic [CLK_W-1:0]  clk_reg;
            logic [PART_W-1:0] prt_reg;
            logic              mask_reg;
            logic              pend_reg;
            logic [ENT_W-1:0]  shadow_reg;

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    clk_reg    <= CLK_W'(gi % NUM_CLOCKS);
                    prt_reg    <= '0;
                    mask_reg   <= 1'b0;
                    pend_reg   <= 1'b0;
                    shadow_reg <= '0;
                end else begin
                    if (cfg_we_i && cfg_row_i == ROW_W'(gi)) begin
                        clk_reg  <= cfg_clk_i;
                        prt_reg  <= cfg_part_i;
                        mask_reg <= cfg_mask_i;
                    end
                    // A capture in the same cycle as the loader's clear keeps the row pending.
                    pend_reg <= cap[gi] | (pend_reg & ~clr[gi]);
                    if (cap[gi])
                        shadow_reg <= {prt_reg, clk_reg, row_data_i[gi*DATA_W +: DATA_W]};
                end
            end

            assign cap[gi]     = ~mask_reg & mclk_edge[clk_reg];
            assign ovr_hit[gi] = cap[gi] & pend_reg & ~clr[gi];
            assign fresh[gi]   = cap[gi] & ~ovr_hit[gi];
            assign pend[gi]    = pend_reg;
            assign tbl_clk[gi] = clk_reg;
            assign shadow[gi]  = shadow_reg;
        end
    endgenerate

    assign fifo_full  = (level_reg == LVL_W'(POOL_DEPTH));
    assign fifo_empty = (level_reg == '0);

    always_comb begin
        ld_idx = '0;
        for (int i = NUM_ROWS - 1; i >= 0; i--)
            if (pend[i]) ld_idx = ROW_W'(i);
        push = (|pend) && !fifo_full;
        clr  = '0;
        if (push) clr[ld_idx] = 1'b1;
    end

    always_comb begin
        for (int c = 0; c < NUM_CLOCKS; c++) begin
            inc_next[c] = '0;
            for (int r = 0; r < NUM_ROWS; r++)
                if (fresh[r] && tbl_clk[r] == CLK_W'(c)) inc_next[c] = inc_next[c] + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) pool_mem[wr_ptr_reg] <= shadow[ld_idx];
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      level_reg <= level_reg + 1'b1;
            else if (!push && pop) level_reg <= level_reg - 1'b1;
        end
    end

    // Fresh captures are counted a cycle late, so freeze follows the capture by one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                inc_reg[c] <= '0;
                out_reg[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CLOCKS; c++) begin
                inc_reg[c] <= inc_next[c];
                out_reg[c] <= out_reg[c] + CNT_W'(inc_reg[c])
                              - CNT_W'(dec_en && pclk_reg == CLK_W'(c));
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_frz
            assign freeze_clk_o[gi] = |out_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        req_next     = req_reg;
        attempt_next = attempt_reg;
        wdog_next    = wdog_reg;
        pop          = 1'b0;
        dec_en       = 1'b0;
        done_inc     = 1'b0;
        fail_set     = 1'b0;
        tmo_set      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (!fifo_empty) begin
                    pop          = 1'b1;
                    req_next     = 1'b1;
                    attempt_next = '0;
                    wdog_next    = '0;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (put.put_ack) begin
                    req_next = 1'b0;
                    if (!put.put_err) begin
                        done_inc   = 1'b1;
                        dec_en     = 1'b1;
                        state_next = S_IDLE;
                    end else if (attempt_reg < AT_W'(MAX_RETRY)) begin
                        attempt_next = attempt_reg + 1'b1;
                        state_next   = S_RETRY;
                    end else begin
                        fail_set   = 1'b1;
                        dec_en     = 1'b1;
                        state_next = S_IDLE;
                    end
                end else if (wdog_reg == WD_W'(TIMEOUT - 1)) begin
                    tmo_set    = 1'b1;
                    dec_en     = 1'b1;
                    req_next   = 1'b0;
                    state_next = S_IDLE;
                end else begin
                    wdog_next = wdog_reg + 1'b1;
                end
            end
            S_RETRY: begin
                req_next   = 1'b1;
                wdog_next  = '0;
                state_next = S_WAIT;
            end
            default: begin
                req_next   = 1'b0;
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg   <= S_IDLE;
            req_reg     <= 1'b0;
            attempt_reg <= '0;
            wdog_reg    <= '0;
            part_reg    <= '0;
            pclk_reg    <= '0;
            data_reg    <= '0;
            done_cnt_o  <= '0;
            overrun_o   <= 1'b0;
            fail_o      <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            req_reg     <= req_next;
            attempt_reg <= attempt_next;
            wdog_reg    <= wdog_next;
            if (pop) {part_reg, pclk_reg, data_reg} <= pool_mem[rd_ptr_reg];
            // Clearing statistics wins over a same-cycle update.
            if (stat_clr_i) begin
                done_cnt_o <= '0;
                overrun_o  <= 1'b0;
                fail_o     <= 1'b0;
                timeout_o  <= 1'b0;
            end else begin
                if (done_inc)  done_cnt_o <= done_cnt_o + 16'd1;
                if (|ovr_hit)  overrun_o  <= 1'b1;
                if (fail_set)  fail_o     <= 1'b1;
                if (tmo_set)   timeout_o  <= 1'b1;
            end
        end
    end

    assign put.put_req  = req_reg;
    assign put.put_part = part_reg;
    assign put.put_clk  = pclk_reg;
    assign put.put_data = data_reg;
    assign pool_level_o = level_reg;
    assign busy_o       = (|pend) || !fifo_empty || (state_reg != S_IDLE);
endmodule

// File: tb/tb_fringe_xchg_sched.sv
// Scoreboard bench for fringe_xchg_sched: expected puts are queued at stimulus time
// and compared when the scheduler raises its put request.
module tb_fringe_xchg_sched;
    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [3:0]  mclk_i;
    logic [35:0] row_data_i;
    logic        cfg_we_i;
    logic [1:0]  cfg_row_i;
    logic [1:0]  cfg_clk_i;
    logic [0:0]  cfg_part_i;
    logic        cfg_mask_i;
    logic [3:0]  freeze_clk_o;
    logic        busy_o;
    logic [2:0]  pool_level_o;
    logic [15:0] done_cnt_o;
    logic        overrun_o, fail_o, timeout_o;
    logic        stat_clr_i;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] sb_q[$];
    logic [31:0] cur;

    fringe_xchg_sched_if #(.PART_W(1), .CLK_W(2), .DATA_W(9)) bus ();

    fringe_xchg_sched dut (
        .clk_i(clk_i), .rst_i(rst_i), .mclk_i(mclk_i), .row_data_i(row_data_i),
        .cfg_we_i(cfg_we_i), .cfg_row_i(cfg_row_i), .cfg_clk_i(cfg_clk_i),
        .cfg_part_i(cfg_part_i), .cfg_mask_i(cfg_mask_i), .put(bus),
        .freeze_clk_o(freeze_clk_o), .busy_o(busy_o), .pool_level_o(pool_level_o),
        .done_cnt_o(done_cnt_o), .overrun_o(overrun_o), .fail_o(fail_o),
        .timeout_o(timeout_o), .stat_clr_i(stat_clr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [31:0] ent(input logic [0:0] p, input logic [1:0] c, input logic [8:0] d);
        return {20'd0, p, c, d};
    endfunction

    function automatic logic [31:0] cur_put();
        return ent(bus.put_part, bus.put_clk, bus.put_data);
    endfunction

    task automatic wait_req(input int max);
        int n = 0;
        while (!bus.put_req && n < max) begin
            tick();
            n++;
        end
        if (!bus.put_req) check("req_wait", 32'(bus.put_req), 32'd1);
    endtask

    // Pop the scoreboard and compare it with the payload now on the bus.
    task automatic take_put(output logic [31:0] e);
        e = '0;
        if (sb_q.size() == 0) check("sb_level", 32'(sb_q.size()), 32'd1);
        else begin
            e = sb_q.pop_front();
            check("put_payload", cur_put(), e);
        end
        $display("put part=%0d clk=%0d data=%03h", bus.put_part, bus.put_clk, bus.put_data);
    endtask

    task automatic expect_put(output logic [31:0] e);
        wait_req(20);
        take_put(e);
    endtask

    task automatic ack_pulse(input logic err);
        bus.put_ack = 1'b1;
        bus.put_err = err;
        tick();
        bus.put_ack = 1'b0;
        bus.put_err = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] r, input logic [1:0] c, input logic m);
        cfg_we_i = 1'b1; cfg_row_i = r; cfg_clk_i = c; cfg_part_i = 1'b0; cfg_mask_i = m;
        tick();
        cfg_we_i = 1'b0;
    endtask

    task automatic clr_stats();
        stat_clr_i = 1'b1;
        tick();
        stat_clr_i = 1'b0;
    endtask

    task automatic mclk_low();
        mclk_i = 4'b0000;
        ticks(3);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_i = 1'b1; mclk_i = '0; cfg_we_i = 0; cfg_row_i = 0; cfg_clk_i = 0;
        cfg_part_i = 0; cfg_mask_i = 0; stat_clr_i = 0;
        bus.put_ack = 0; bus.put_err = 0;
        row_data_i = {9'h1A5, 9'h133, 9'h022, 9'h011};
        ticks(2);
        check("rst_req", 32'(bus.put_req), 0);
        check("rst_level", 32'(pool_level_o), 0);
        check("rst_done", 32'(done_cnt_o), 0);
        check("rst_freeze", 32'(freeze_clk_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_flags", {29'd0, overrun_o, fail_o, timeout_o}, 0);
        rst_i = 1'b0;
        ticks(2);

        // Single capture on mclk 3: latency and freeze window.
        sb_q.push_back(ent(0, 3, 9'h1A5));
        mclk_i[3] = 1'b1;
        tick();
        tick();
        check("t1_freeze_k1", 32'(freeze_clk_o), 0);
        check("t1_busy_k1", 32'(busy_o), 1);
        tick();
        check("t1_freeze_k2", 32'(freeze_clk_o), 32'b1000);
        check("t1_level_k2", 32'(pool_level_o), 1);
        check("t1_req_k2", 32'(bus.put_req), 0);
        tick();
        check("t1_req_k3", 32'(bus.put_req), 1);
        take_put(cur);
        ack_pulse(1'b0);
        check("t1_req_after", 32'(bus.put_req), 0);
        check("t1_freeze_after", 32'(freeze_clk_o), 0);
        check("t1_done", 32'(done_cnt_o), 1);
        check("t1_busy", 32'(busy_o), 0);

        // All four clocks at once: queue builds behind a stalled put, row order kept.
        clr_stats();
        mclk_low();
        for (int r = 0; r < 4; r++) sb_q.push_back(ent(0, 2'(r), row_data_i[r*9 +: 9]));
        mclk_i = 4'b1111;
        wait_req(20);
        ticks(10);
        check("t2_level", 32'(pool_level_o), 3);
        check("t2_req_held", 32'(bus.put_req), 1);
        check("t2_freeze", 32'(freeze_clk_o), 32'b1111);
        for (int i = 0; i < 4; i++) begin
            expect_put(cur);
            ack_pulse(1'b0);
        end
        check("t2_done", 32'(done_cnt_o), 4);
        check("t2_freeze_end", 32'(freeze_clk_o), 0);

        // Masked row produces nothing.
        mclk_low();
        cfg(2'd1, 2'd1, 1'b1);
        mclk_i[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t3_req", 32'(bus.put_req), 0);
            check("t3_freeze", 32'(freeze_clk_o), 0);
            check("t3_busy", 32'(busy_o), 0);
        end
        cfg(2'd1, 2'd1, 1'b0);

        // Two error acks then success: three attempts with one-cycle gaps.
        mclk_low();
        sb_q.push_back(ent(0, 2, 9'h133));
        mclk_i[2] = 1'b1;
        expect_put(cur);
        for (int a = 0; a < 2; a++) begin
            ack_pulse(1'b1);
            check("t4_gap", 32'(bus.put_req), 0);
            tick();
            check("t4_retry_req", 32'(bus.put_req), 1);
            check("t4_retry_payload", cur_put(), cur);
        end
        ack_pulse(1'b0);
        check("t4_done", 32'(done_cnt_o), 5);
        check("t4_fail", 32'(fail_o), 0);
        check("t4_req_end", 32'(bus.put_req), 0);

        // Error on every ack: gives up after three attempts.
        mclk_low();
        sb_q.push_back(ent(0, 2, 9'h133));
        mclk_i[2] = 1'b1;
        expect_put(cur);
        for (int a = 0; a < 3; a++) begin
            ack_pulse(1'b1);
            check("t4b_gap", 32'(bus.put_req), 0);
            if (a < 2) begin
                tick();
                check("t4b_retry_req", 32'(bus.put_req), 1);
            end
        end
        check("t4b_fail", 32'(fail_o), 1);
        check("t4b_freeze", 32'(freeze_clk_o), 0);
        ticks(3);
        check("t4b_no_req", 32'(bus.put_req), 0);
        check("t4b_done", 32'(done_cnt_o), 5);

        // No ack: watchdog drops the request after TIMEOUT cycles.
        clr_stats();
        mclk_low();
        sb_q.push_back(ent(0, 0, 9'h011));
        mclk_i[0] = 1'b1;
        expect_put(cur);
        begin
            int cnt = 1;
            for (int i = 0; i < 200; i++) begin
                tick();
                if (!bus.put_req) break;
                cnt++;
            end
            check("t5_req_len", 32'(cnt), 64);
        end
        check("t5_timeout", 32'(timeout_o), 1);
        check("t5_freeze", 32'(freeze_clk_o), 0);
        check("t5_busy", 32'(busy_o), 0);
        check("t5_done", 32'(done_cnt_o), 0);

        // Overrun: all rows on clk 0 with the transport stalled, then reset mid-WAIT.
        clr_stats();
        for (int r = 1; r < 4; r++) cfg(2'(r), 2'd0, 1'b0);
        mclk_low();
        mclk_i[0] = 1'b1;
        ticks(8);
        check("t6_level_a", 32'(pool_level_o), 3);
        mclk_low();
        mclk_i[0] = 1'b1;
        ticks(4);
        check("t6_level_full", 32'(pool_level_o), 4);
        check("t6_no_overrun", 32'(overrun_o), 0);
        mclk_low();
        mclk_i[0] = 1'b1;
        ticks(3);
        check("t6_overrun", 32'(overrun_o), 1);
        check("t6_req", 32'(bus.put_req), 1);
        check("t6_freeze", 32'(freeze_clk_o), 32'b0001);
        @(posedge clk_i);
        #3;
        rst_i = 1'b1;
        mclk_i = '0;
        #1;
        check("t6_rst_req", 32'(bus.put_req), 0);
        check("t6_rst_level", 32'(pool_level_o), 0);
        check("t6_rst_freeze", 32'(freeze_clk_o), 0);
        check("t6_rst_busy", 32'(busy_o), 0);
        check("t6_rst_overrun", 32'(overrun_o), 0);
        tick();
        rst_i = 1'b0;
        ticks(2);

        // Table back to defaults: row 1 answers mclk 1 again.
        sb_q.push_back(ent(0, 1, 9'h022));
        mclk_i[1] = 1'b1;
        expect_put(cur);
        ack_pulse(1'b0);
        check("t7_done", 32'(done_cnt_o), 1);
        ticks(6);
        check("t7_idle_req", 32'(bus.put_req), 0);
        check("t7_sb_empty", 32'(sb_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
